// File: rtl/pattern_seq_pkg.sv
// Shared types and default sizing for the LED pattern record/playback controller.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_e;

  localparam int unsigned DEFAULT_STEP_COUNT = 12000000;
  localparam int unsigned DEFAULT_DEPTH      = 8;

endpackage

// File: rtl/step_tick_gen.sv
// Free-running step timer: pulses tick for one cycle at terminal count while enabled,
// holds its value while disabled, and clr returns it to zero with priority.
module step_tick_gen
  import pattern_seq_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned STEP_COUNT  = DEFAULT_STEP_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(STEP_COUNT - 1);

  logic [COUNT_WIDTH-1:0] timer_q;
  logic [COUNT_WIDTH-1:0] timer_d;

  assign tick = en && (timer_q == LAST);

  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (en) begin
      timer_d = (timer_q == LAST) ? '0 : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Record/playback controller: captures button patterns into a small memory and
// loops through them on the LEDs at a fixed step period, with pause and clear.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned PAT_WIDTH   = 2,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned PTR_WIDTH   = 3,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned STEP_COUNT  = DEFAULT_STEP_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_stb,
  input  logic                 play_stb,
  input  logic                 clr_stb,
  input  logic [PAT_WIDTH-1:0] pattern_in,
  output logic [PAT_WIDTH-1:0] leds,
  output logic                 playing,
  output logic                 empty,
  output logic                 full,
  output logic                 wrap,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);

  seq_state_e             state_q, state_d;
  logic [PTR_WIDTH:0]     count_q, count_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PAT_WIDTH-1:0]   leds_q, leds_d;
  logic [PAT_WIDTH-1:0]   mem_q [DEPTH];

  logic                   wr_en;
  logic                   timer_clr;
  logic                   tick;
  logic [PTR_WIDTH-1:0]   last_idx;
  logic [PTR_WIDTH-1:0]   nxt_ptr;

  step_tick_gen #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .STEP_COUNT  (STEP_COUNT)
  ) u_step_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == PLAY),
    .clr  (timer_clr),
    .tick (tick)
  );

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign playing  = (state_q == PLAY);
  assign leds     = leds_q;

  // Step advance wraps on the pre-write count, so a same-cycle write joins next loop.
  assign last_idx = PTR_WIDTH'(count_q - 1'b1);
  assign nxt_ptr  = (rd_ptr_q == last_idx) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    leds_d    = leds_q;
    wr_en     = 1'b0;
    timer_clr = 1'b0;
    wrap      = 1'b0;
    overflow  = 1'b0;

    if (clr_stb) begin
      state_d   = EMPTY;
      count_d   = '0;
      rd_ptr_d  = '0;
      leds_d    = '0;
      timer_clr = 1'b1;
    end else begin
      if (tick) begin
        rd_ptr_d = nxt_ptr;
        leds_d   = mem_q[nxt_ptr];
        wrap     = (nxt_ptr == '0);
      end

      if (set_stb) begin
        if (full) begin
          overflow = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (state_q == EMPTY) begin
            state_d   = PLAY;
            rd_ptr_d  = '0;
            leds_d    = pattern_in;
            timer_clr = 1'b1;
          end
        end
      end

      if (play_stb) begin
        case (state_q)
          PLAY:    state_d = PAUSE;
          PAUSE:   state_d = PLAY;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      rd_ptr_q <= '0;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      leds_q   <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q[PTR_WIDTH-1:0]] <= pattern_in;
    end
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a queue-based playback model checked every cycle.
module tb_pattern_seq_ctrl;

  localparam int SC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_stb = 1'b0;
  logic       play_stb = 1'b0;
  logic       clr_stb = 1'b0;
  logic [1:0] pattern_in = 2'b00;
  logic [1:0] leds;
  logic       playing, empty, full, wrap, overflow;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  cmp_en = 1'b0;

  pattern_seq_ctrl #(
    .PAT_WIDTH   (2),
    .DEPTH       (DEPTH),
    .PTR_WIDTH   (2),
    .COUNT_WIDTH (24),
    .STEP_COUNT  (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_stb    (set_stb),
    .play_stb   (play_stb),
    .clr_stb    (clr_stb),
    .pattern_in (pattern_in),
    .leds       (leds),
    .playing    (playing),
    .empty      (empty),
    .full       (full),
    .wrap       (wrap),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endfunction

  // Model: stored patterns in a queue; playback position is an index modulo the queue size.
  logic [1:0] m_pats[$];
  bit m_act = 1'b0;
  bit m_run = 1'b0;
  int m_tmr = 0;
  int m_idx = 0;
  int m_leds = 0;
  int m_n;
  bit m_was_act;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pats.delete();
      m_act = 0; m_run = 0; m_tmr = 0; m_idx = 0; m_leds = 0;
    end else if (clr_stb) begin
      m_pats.delete();
      m_act = 0; m_run = 0; m_tmr = 0; m_idx = 0; m_leds = 0;
    end else begin
      m_n = m_pats.size();
      m_was_act = m_act;
      if (m_act && m_run) begin
        if (m_tmr == SC - 1) begin
          m_tmr  = 0;
          m_idx  = (m_idx + 1) % m_n;
          m_leds = int'(m_pats[m_idx]);
        end else begin
          m_tmr++;
        end
      end
      if (set_stb && m_n < DEPTH) begin
        m_pats.push_back(pattern_in);
        if (!m_was_act) begin
          m_act = 1; m_run = 1; m_idx = 0; m_tmr = 0; m_leds = int'(pattern_in);
        end
      end
      if (play_stb && m_was_act) m_run = !m_run;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("leds", int'(leds), m_leds);
      chk("playing", int'(playing), int'(m_act && m_run));
      chk("empty", int'(empty), int'(m_pats.size() == 0));
      chk("full", int'(full), int'(m_pats.size() == DEPTH));
      chk("wrap", int'(wrap), int'(!clr_stb && m_act && m_run && m_tmr == SC - 1 &&
                                   ((m_idx + 1) % m_pats.size()) == 0));
      chk("overflow", int'(overflow), int'(set_stb && !clr_stb && m_pats.size() == DEPTH));
    end
  end

  task automatic pulse_set(input logic [1:0] p);
    @(posedge clk); #1;
    set_stb = 1'b1; pattern_in = p;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_stb = 1'b1;
    @(posedge clk); #1;
    clr_stb = 1'b0;
  endtask

  task automatic pulse_play();
    @(posedge clk); #1;
    play_stb = 1'b1;
    @(posedge clk); #1;
    play_stb = 1'b0;
  endtask

  // Leaves the caller at the negedge of the cycle in which wrap is high.
  task automatic wait_wrap(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (wrap) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  int wraps;
  int lval;
  int steps;
  bit changed;

  initial begin
    logic [1:0] loop3 [12];
    logic [1:0] loop4 [4];
    loop3 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    loop4 = '{2'd1, 2'd2, 2'd3, 2'd0};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_leds", int'(leds), 0);
    chk("rst_empty", int'(empty), 1);

    // Single entry: visible next cycle, wrap every SC clocks.
    pulse_set(2'b01);
    chk("single_leds", int'(leds), 1);
    chk("single_playing", int'(playing), 1);
    wraps = 0;
    repeat (12) begin
      @(negedge clk);
      if (wrap) wraps++;
    end
    chk("single_wraps", wraps, 3);

    // Three-entry loop: each value held SC clocks, wrap only on the last one.
    pulse_clr();
    pulse_set(2'b01);
    pulse_set(2'b10);
    pulse_set(2'b11);
    wait_wrap("loop_wrap_seen");
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("loop_seq", int'(leds), int'(loop3[i]));
      if (wrap) wraps = wraps + ((i == 11) ? 1 : 100);
    end
    chk("loop_wrap_pos", wraps, 1);

    // Fill, then overflow leaves count and contents intact.
    pulse_set(2'b00);
    chk("full_flag", int'(full), 1);
    @(posedge clk); #1;
    set_stb = 1'b1; pattern_in = 2'b00;
    @(negedge clk);
    chk("ovf_pulse", int'(overflow), 1);
    @(posedge clk); #1;
    set_stb = 1'b0;
    @(negedge clk);
    chk("ovf_one_cycle", int'(overflow), 0);
    wait_wrap("full_wrap_seen");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("full_seq", int'(leds), int'(loop4[i]));
      repeat (SC - 1) @(posedge clk);
    end

    // Pause one clock after a step, hold, then resume from the held timer.
    wait_wrap("pause_wrap_seen");
    @(posedge clk); #1;
    lval = int'(leds);
    chk("pause_start_val", lval, 1);
    play_stb = 1'b1;
    @(posedge clk); #1;
    play_stb = 1'b0;
    repeat (20) @(negedge clk);
    chk("pause_frozen", int'(leds), lval);
    chk("pause_playing", int'(playing), 0);
    pulse_play();
    steps = 0;
    changed = 1'b0;
    while (!changed && steps < 10) begin
      @(posedge clk); #1;
      steps++;
      if (int'(leds) != lval) changed = 1'b1;
    end
    chk("resume_steps", steps, 3);

    // Clear wins over a simultaneous set, even while full.
    @(posedge clk); #1;
    clr_stb = 1'b1; set_stb = 1'b1; pattern_in = 2'b11;
    @(negedge clk);
    chk("clr_no_ovf", int'(overflow), 0);
    @(posedge clk); #1;
    clr_stb = 1'b0; set_stb = 1'b0;
    chk("clr_empty", int'(empty), 1);
    chk("clr_leds", int'(leds), 0);
    chk("clr_playing", int'(playing), 0);
    pulse_set(2'b10);
    chk("clr_then_set", int'(leds), 2);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_leds", int'(leds), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_playing", int'(playing), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
Record/playback controller for the LED pattern sequencer. It captures debounced pattern-button samples into a small register-file pattern memory on each "set" strobe. It then steps through the stored entries on the LEDs at a fixed step period, looping continuously, with pause/resume and clear. It sits between the button debouncers (which supply 1-cycle strobes) and the board LED pins.

Parameters:
PAT_WIDTH, 2, bits per pattern entry (= number of LEDs)
DEPTH, 8, pattern memory entries; power of two
PTR_WIDTH, 3, log2(DEPTH)
COUNT_WIDTH, 24, step timer width
STEP_COUNT, 12000000, clocks per playback step (1 s at 12 MHz); must be >= 2 and fit in COUNT_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
set_stb  in  1  1-cycle strobe: record pattern_in
play_stb  in  1  1-cycle strobe: toggle play/pause
clr_stb  in  1  1-cycle strobe: erase all entries
pattern_in  in  PAT_WIDTH  active-high pattern to record (inverted upstream)
leds  out  PAT_WIDTH  registered LED drive
playing  out  1  high in PLAY state
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
wrap  out  1  1-cycle pulse when playback returns to entry 0
overflow  out  1  1-cycle pulse when set_stb arrives while full

Behaviour:
- Interface: single clock clk; rst is asynchronous, active-high. All state clears immediately on rst assertion.
- Reset values:
  - state=EMPTY, count=0 (PTR_WIDTH+1 bits), rd_ptr=0, timer=0.
  - leds=0, playing=0, empty=1, full=0, wrap=0, overflow=0.
  - Memory contents are don't-care.
- States:
  - EMPTY: leds=0; timer idle.
  - PLAY: timer runs; leds=mem[rd_ptr].
  - PAUSE: timer, rd_ptr and leds frozen.
- Priority in any cycle: clr_stb > set_stb/play_stb.
- clr_stb: next state EMPTY; count, rd_ptr, timer <= 0; leds <= 0; overflow/wrap stay 0 that cycle.
- set_stb with count<DEPTH: mem[count] <= pattern_in; count <= count+1.
  - From EMPTY: state <= PLAY, rd_ptr <= 0, timer <= 0, leds <= pattern_in (bypass, visible the cycle after the strobe edge).
  - In PLAY/PAUSE: state and leds are unchanged; the new entry joins the loop at the next wrap.
- set_stb with count==DEPTH: memory and count unchanged; overflow=1 for one cycle.
- play_stb: PLAY->PAUSE or PAUSE->PLAY; ignored in EMPTY. The timer resumes from its held value; it is not reset.
- set_stb and play_stb in the same cycle: both take effect. From EMPTY, the write moves the state to PLAY and play_stb is ignored.
- Timer, in PLAY only:
  - timer increments 0..STEP_COUNT-1.
  - At STEP_COUNT-1: timer <= 0; nxt = (rd_ptr==count-1) ? 0 : rd_ptr+1; rd_ptr <= nxt; leds <= mem[nxt].
  - wrap=1 that cycle when nxt==0, including the count==1 case, where wrap pulses every step.
  - A step advance uses the pre-write count when set_stb occurs in the same cycle.
- Write/read collision: the write index (count) is always > rd_ptr, so no bypass is needed except the EMPTY case above.
- Flags are combinational from state/count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - playing = (state==PLAY)
- Step period is exactly STEP_COUNT clocks between leds changes while in PLAY.

Decomposition:
- Package pattern_seq_pkg holds:
  - state encoding: EMPTY=2'd0, PLAY=2'd1, PAUSE=2'd2
  - default STEP_COUNT and DEPTH constants
- One sub-module, step_tick_gen (params COUNT_WIDTH, STEP_COUNT):
  - inputs: clk, rst, en, clr
  - output: 1-cycle tick at terminal count
  - holds its value while en=0
- Memory, pointers and FSM stay in pattern_seq_ctrl.

Test Plan:
All scenarios use STEP_COUNT=4, DEPTH=4.
1. Reset: assert rst mid-cycle -> leds=00, empty=1, playing=0 immediately, with no clock edge.
2. Single entry: set_stb with pattern_in=01 -> leds=01 and playing=1 the next cycle; wrap pulses every 4 clocks; leds stay 01.
3. Loop: record 01, 10, 11 -> leds sequence 01,10,11,01,… with each value held exactly 4 clocks; wrap=1 on the 11->01 edge only.
4. Full/overflow: record 4 entries -> full=1; a 5th set_stb with 00 -> overflow pulse; count stays 4; the loop still shows only the original 4 entries.
5. Pause: play_stb 1 clock after a step -> leds frozen for 20 clocks; second play_stb -> next step after exactly 3 more clocks.
6. Clear priority: clr_stb and set_stb in the same cycle while playing -> empty=1, leds=00, playing=0; a following set_stb 10 -> leds=10 the next cycle.
